// File: rtl/st_mux_pkg.sv
// Shared types and the rotate-priority search used by the st_rr_mux arbiter.
package st_mux_pkg;

  localparam int unsigned MAX_IN  = 16;
  localparam int unsigned MAX_CHW = 4;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  typedef struct packed {
    logic               found;
    logic [MAX_CHW-1:0] idx;
  } pick_t;

  // First set bit of req searching ptr, ptr+1, ... modulo n.
  function automatic pick_t rr_pick(input logic [MAX_IN-1:0]  req,
                                    input logic [MAX_CHW-1:0] ptr,
                                    input int unsigned        n);
    pick_t       p;
    int unsigned c;
    p = '0;
    for (int unsigned k = 0; k < MAX_IN; k++) begin
      c = 32'(ptr) + k;
      if (c >= n) c = c - n;
      if ((k < n) && !p.found && req[c[MAX_CHW-1:0]]) begin
        p.found = 1'b1;
        p.idx   = MAX_CHW'(c);
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/st_rr_arbiter.sv
// Combinational round-robin picker: lowest requesting channel at or after rr_ptr.
module st_rr_arbiter
  import st_mux_pkg::*;
#(
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned CHWIDTH = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]  req,
  input  logic [CHWIDTH-1:0] rr_ptr,
  output logic [CHWIDTH-1:0] sel,
  output logic               any_req
);

  pick_t pick;

  always_comb begin
    pick    = rr_pick(MAX_IN'(req), MAX_CHW'(rr_ptr), NUM_IN);
    any_req = pick.found;
    sel     = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (pick.idx == MAX_CHW'(i)) sel = CHWIDTH'(i);
    end
  end

endmodule

// File: rtl/st_rr_mux.sv
// N-input streaming mux with round-robin arbitration and a registered output slot.
// Define ST_RR_MUX_PKT_LOCK_EN to hold the grant for a whole packet; otherwise arbitration is per beat.
module st_rr_mux
  import st_mux_pkg::*;
#(
  parameter int unsigned DWIDTH  = 8,
  parameter int unsigned NUM_IN  = 4,
  parameter int unsigned CHWIDTH = $clog2(NUM_IN)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [NUM_IN-1:0]        in_valid,
  output logic [NUM_IN-1:0]        in_ready,
  input  logic [NUM_IN*DWIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]        in_eop,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DWIDTH-1:0]        out_data,
  output logic                     out_eop,
  output logic [CHWIDTH-1:0]       out_channel
);

  state_e               state_q, state_d;
  logic [CHWIDTH-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CHWIDTH-1:0]   grant_q, grant_d;
  logic                 out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]    out_data_q, out_data_d;
  logic                 out_eop_q, out_eop_d;
  logic [CHWIDTH-1:0]   out_channel_q, out_channel_d;

  logic [CHWIDTH-1:0]   arb_sel, sel;
  logic                 arb_any, have, slot_free, xfer;
  logic                 sel_valid, sel_eop;
  logic [DWIDTH-1:0]    sel_data;
  logic [NUM_IN-1:0]    rdy_c;

  function automatic logic [CHWIDTH-1:0] next_ch(input logic [CHWIDTH-1:0] c);
    return (c == CHWIDTH'(NUM_IN - 1)) ? '0 : c + CHWIDTH'(1);
  endfunction

  st_rr_arbiter #(
    .NUM_IN  (NUM_IN),
    .CHWIDTH (CHWIDTH)
  ) u_arb (
    .req     (in_valid),
    .rr_ptr  (rr_ptr_q),
    .sel     (arb_sel),
    .any_req (arb_any)
  );

  // Channel selection and the per-channel accept strobes.
  always_comb begin
    slot_free = !out_valid_q || out_ready;
    sel       = (state_q == LOCKED) ? grant_q : arb_sel;
    have      = (state_q == LOCKED) || arb_any;
    sel_valid = 1'b0;
    sel_eop   = 1'b0;
    sel_data  = '0;
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      if (sel == CHWIDTH'(i)) begin
        sel_valid = in_valid[i];
        sel_eop   = in_eop[i];
        sel_data  = in_data[i*DWIDTH +: DWIDTH];
      end
    end
    // Reset gating keeps in_ready low while reset_n is asserted.
    for (int unsigned i = 0; i < NUM_IN; i++) begin
      rdy_c[i] = reset_n && slot_free && have && (sel == CHWIDTH'(i));
    end
    xfer = have && slot_free && sel_valid;
  end

  // Next-state, pointer and output-slot logic.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    grant_d       = grant_q;
    out_valid_d   = out_valid_q;
    out_data_d    = out_data_q;
    out_eop_d     = out_eop_q;
    out_channel_d = out_channel_q;

    if (xfer) begin
      out_valid_d   = 1'b1;
      out_data_d    = sel_data;
      out_eop_d     = sel_eop;
      out_channel_d = sel;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (xfer) begin
`ifdef ST_RR_MUX_PKT_LOCK_EN
          if (sel_eop) begin
            rr_ptr_d = next_ch(sel);
          end else begin
            grant_d = sel;
            state_d = LOCKED;
          end
`else
          rr_ptr_d = next_ch(sel);
`endif
        end
      end
      LOCKED: begin
        if (xfer && sel_eop) begin
          rr_ptr_d = next_ch(grant_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      rr_ptr_q      <= '0;
      grant_q       <= '0;
      out_valid_q   <= 1'b0;
      out_data_q    <= '0;
      out_eop_q     <= 1'b0;
      out_channel_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      grant_q       <= grant_d;
      out_valid_q   <= out_valid_d;
      out_data_q    <= out_data_d;
      out_eop_q     <= out_eop_d;
      out_channel_q <= out_channel_d;
    end
  end

  assign in_ready    = rdy_c;
  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_eop     = out_eop_q;
  assign out_channel = out_channel_q;

endmodule
